dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters:
  - the single-cycle core's load/store path (requester 0, "core");
  - a program/data loader or debug port (requester 1, "ldr").
- Arbitrates every cycle and routes the granted request to memory.
- Steers the one-cycle-late read data back to its owner.
- Raises core_stall so the datapath holds its PC and register write while it waits.

Parameters:
- AW, 10, memory word-address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced a grant; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core access request (memread | memwrite)
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core word address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core request accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid
- core_rdata  out  DW  read data to core
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write enable
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_gnt  out  1  loader request accepted
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  DW  read data to loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe

Behaviour:
- Grant is combinational from the requests and registered state. Nothing in the request-to-grant-to-mem path is registered.
- Priority:
  - core wins when starve_cnt < STARVE_LIMIT;
  - ldr wins when starve_cnt == STARVE_LIMIT and ldr_req = 1;
  - a lone requester is always granted;
  - at most one grant per cycle.
- Memory outputs:
  - mem_en = core_gnt | ldr_gnt;
  - mem_we/addr/wdata are muxed from the granted requester;
  - all are 0 when there is no grant.
- starve_cnt (8-bit register):
  - increments when ldr_req & ~ldr_gnt;
  - saturates at STARVE_LIMIT;
  - clears when ldr_gnt or ~ldr_req.
- Read-owner FSM (rd_owner), states R_NONE, R_CORE, R_LDR:
  - next state = R_CORE on a granted core read;
  - R_LDR on a granted ldr read;
  - R_NONE otherwise (writes or idle).
  - Back-to-back reads are permitted; the state changes every cycle.
- Read response:
  - core_rvalid = (rd_owner == R_CORE); ldr_rvalid = (rd_owner == R_LDR).
  - Both rdata outputs = mem_rdata when their rvalid = 1, else 0.
  - Read latency is exactly 1 cycle after the grant.
- Writes take effect at the granted edge and produce no response.
- Requesters hold request fields stable until granted. Dropping a request before grant is legal and has no side effect.
- Reset values: rd_owner = R_NONE, starve_cnt = 0. All rvalid outputs are 0 immediately and asynchronously.
- Reset asserted mid-read discards the pending response; no rvalid follows.
- Same-address write by one requester followed by a read by the other: ordering is strictly by grant order.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - adds outputs conflict_cnt[31:0], incremented when core_req & ldr_req;
  - adds outputs forced_cnt[31:0], incremented when the loader is granted by starvation override;
  - both are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - rd_owner_t enum (R_NONE, R_CORE, R_LDR);
  - STARVE_CNT_W = 8;
  - localparam defaults for AW and DW.
- Sub-module dmem_arb_starve_ctr: saturating counter with inc/clr inputs and an at_limit output.

Test Plan:
- Core-only reads at addr 0x004 and 0x008 back-to-back:
  - core_gnt = 1 both cycles, core_stall = 0;
  - core_rvalid high on cycles 2 and 3 with the memory words;
  - ldr_rvalid stays 0.
- Loader writes 0xDEADBEEF to 0x010, then the core reads 0x010 → core_rdata = 0xDEADBEEF one cycle after the core grant.
- Continuous core_req and ldr_req with STARVE_LIMIT = 4:
  - pattern is 4 core grants, 1 loader grant, repeated;
  - core_stall is high exactly on the loader-grant cycles.
- Core read granted, then reset pulsed during the response cycle → core_rvalid = 0 immediately; starve_cnt = 0 after reset.
- Loader read immediately followed by core read → ldr_rvalid then core_rvalid on consecutive cycles, each with the correct word and no cross-routing.
- With DMEM_ARB_PERF_EN, 10 cycles of continuous dual requests at STARVE_LIMIT = 4 → conflict_cnt = 10, forced_cnt = 2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory port arbiter.
//   rd_owner_t   : which requester owns the read response in flight
//   STARVE_CNT_W : width of the loader starvation counter
//   AW_DEF/DW_DEF: default address / data widths
package dmem_arb_pkg;

    localparam int AW_DEF       = 10;
    localparam int DW_DEF       = 32;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_CORE = 2'd1,
        R_LDR  = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr
//   Saturating counter of consecutive loader denials.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     inc_i       : loader requested and was denied this cycle
//     clr_i       : loader was granted or is not requesting
//     at_limit_o  : counter has reached LIMIT (loader must win next)
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != LIMIT_C))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a single-port, synchronous-read data memory between the core
//   load/store path (requester 0) and a loader/debug port (requester 1).
//   The core has priority unless the loader has been denied STARVE_LIMIT
//   cycles in a row. Read data (one cycle after the grant) is steered back
//   to whichever requester issued the read.
//   Ports:
//     clk, reset                         : clock, async active-high reset
//     core_req/we/addr/wdata             : core request
//     core_gnt, core_stall               : core accepted / must hold
//     core_rvalid, core_rdata            : core read response
//     ldr_req/we/addr/wdata              : loader request
//     ldr_gnt, ldr_rvalid, ldr_rdata     : loader grant / read response
//     mem_en/we/addr/wdata, mem_rdata    : memory port
//   Optional build macro DMEM_ARB_PERF_EN adds conflict_cnt / forced_cnt
//   performance counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   forced_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    logic      at_limit;
    rd_owner_t rd_owner_q, rd_owner_d;

    // ---------------- arbitration (purely combinational) ----------------
    // Loader wins when alone or when it has starved long enough; the core
    // takes everything else, so at most one grant is ever asserted.
    always_comb begin
        ldr_gnt    = ldr_req & (~core_req | at_limit);
        core_gnt   = core_req & ~ldr_gnt;
        core_stall = core_req & ~core_gnt;
    end

    always_comb begin
        mem_en    = core_gnt | ldr_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (ldr_req & ~ldr_gnt),
        .clr_i      (ldr_gnt | ~ldr_req),
        .at_limit_o (at_limit)
    );

    // ---------------- read-owner FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_owner_q <= R_NONE;
        else       rd_owner_q <= rd_owner_d;
    end

    // Next owner depends only on this cycle's grant, so back-to-back reads
    // from either side simply retarget the next response.
    always_comb begin
        rd_owner_d = R_NONE;
        if (core_gnt && !core_we)
            rd_owner_d = R_CORE;
        else if (ldr_gnt && !ldr_we)
            rd_owner_d = R_LDR;
    end

    // Outputs decode the register directly, so reset kills rvalid at once.
    always_comb begin
        core_rvalid = (rd_owner_q == R_CORE);
        ldr_rvalid  = (rd_owner_q == R_LDR);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        ldr_rdata   = ldr_rvalid  ? mem_rdata : '0;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_q, forced_q;

    // A loader grant while the core is also requesting can only come from
    // the starvation override.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
            forced_q   <= '0;
        end else begin
            if (core_req && ldr_req)  conflict_q <= conflict_q + 32'd1;
            if (ldr_gnt && core_req)  forced_q   <= forced_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign forced_cnt   = forced_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, ldr_req, ldr_we;
    logic [AW-1:0] core_addr, ldr_addr;
    logic [DW-1:0] core_wdata, ldr_wdata;
    logic          core_gnt, core_stall, core_rvalid, ldr_gnt, ldr_rvalid;
    logic [DW-1:0] core_rdata, ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   conflict_cnt, forced_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // synchronous-read single-port memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ldr_req     (ldr_req),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_gnt     (ldr_gnt),
        .ldr_rvalid  (ldr_rvalid),
        .ldr_rdata   (ldr_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
`ifdef DMEM_ARB_PERF_EN
        .conflict_cnt(conflict_cnt),
        .forced_cnt  (forced_cnt),
`endif
        .mem_rdata   (mem_rdata)
    );

    // inputs change 1 time unit after the rising edge, checks 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        ldr_req  = 0; ldr_we  = 0; ldr_addr  = '0; ldr_wdata  = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (core_rvalid !== 1'b0 || ldr_rvalid !== 1'b0 || mem_en !== 1'b0 || core_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: core_rvalid=%b ldr_rvalid=%b mem_en=%b core_gnt=%b want 0 0 0 0",
                     core_rvalid, ldr_rvalid, mem_en, core_gnt);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_core_reads();
        core_req = 1; core_we = 0; core_addr = 10'h004;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || core_stall !== 1'b0 || mem_addr !== 10'h004 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL core_rd0_grant: gnt=%b stall=%b addr=%h en=%b want 1 0 004 1",
                     core_gnt, core_stall, mem_addr, mem_en);
        end
        tick();
        core_addr = 10'h008;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || core_stall !== 1'b0 || core_rvalid !== 1'b1 ||
            core_rdata !== 32'h1111_0004 || ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_rd0_resp: gnt=%b stall=%b rvalid=%b rdata=%h lrv=%b want 1 0 1 11110004 0",
                     core_gnt, core_stall, core_rvalid, core_rdata, ldr_rvalid);
        end
        tick();
        idle();
        #1;
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'h2222_0008 || ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_rd1_resp: rvalid=%b rdata=%h lrv=%b want 1 22220008 0",
                     core_rvalid, core_rdata, ldr_rvalid);
        end
        tick();
        checks++;
        if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL core_rd_idle: rvalid=%b rdata=%h want 0 0", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_ldr_write_core_read();
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h010; ldr_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ldr_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ldr_write: gnt=%b we=%b addr=%h wdata=%h want 1 1 010 deadbeef",
                     ldr_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        idle();
        core_req = 1; core_addr = 10'h010;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || ldr_rvalid !== 1'b0 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_then_rd_grant: cgnt=%b lrv=%b crv=%b want 1 0 0", core_gnt, ldr_rvalid, core_rvalid);
        end
        tick();
        idle();
        #1;
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_then_rd_data: rvalid=%b rdata=%h want 1 deadbeef", core_rvalid, core_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        core_req = 1; core_we = 0; core_addr = 10'h004;
        ldr_req  = 1; ldr_we  = 0; ldr_addr  = 10'h008;
        for (int i = 0; i < 10; i++) begin
            logic exp_l;
            exp_l = ((i % 5) == 4);
            #1;
            checks++;
            if (ldr_gnt !== exp_l || core_gnt !== ~exp_l || core_stall !== exp_l) begin
                errors++;
                $display("FAIL starve_cycle%0d: lgnt=%b cgnt=%b stall=%b want %b %b %b",
                         i, ldr_gnt, core_gnt, core_stall, exp_l, ~exp_l, exp_l);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        // three denied loader cycles build up the starvation count
        core_req = 1; core_we = 0; core_addr = 10'h004;
        ldr_req  = 1; ldr_we  = 0; ldr_addr  = 10'h008;
        tick(); tick(); tick();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'h1111_0004) begin
            errors++;
            $display("FAIL pre_reset_resp: rvalid=%b rdata=%h want 1 11110004", core_rvalid, core_rdata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_rvalid: rvalid=%b rdata=%h want 0 0", core_rvalid, core_rdata);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (core_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_no_resp: crv=%b lrv=%b want 0 0", core_rvalid, ldr_rvalid);
        end
        // a cleared counter means four core grants before the loader wins
        for (int i = 0; i < 5; i++) begin
            logic exp_l;
            exp_l = (i == 4);
            #1;
            checks++;
            if (ldr_gnt !== exp_l || core_gnt !== ~exp_l) begin
                errors++;
                $display("FAIL starve_clear_cycle%0d: lgnt=%b cgnt=%b want %b %b",
                         i, ldr_gnt, core_gnt, exp_l, ~exp_l);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_ldr_then_core();
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h008;
        tick();
        idle();
        core_req = 1; core_addr = 10'h004;
        #1;
        checks++;
        if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'h2222_0008 || core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ldr_resp: lrv=%b lrd=%h crv=%b crd=%h want 1 22220008 0 0",
                     ldr_rvalid, ldr_rdata, core_rvalid, core_rdata);
        end
        tick();
        idle();
        #1;
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'h1111_0004 || ldr_rvalid !== 1'b0 || ldr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL core_after_ldr: crv=%b crd=%h lrv=%b lrd=%h want 1 11110004 0 0",
                     core_rvalid, core_rdata, ldr_rvalid, ldr_rdata);
        end
        tick();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_req = 1; core_addr = 10'h004;
        ldr_req  = 1; ldr_addr  = 10'h008;
        for (int i = 0; i < 10; i++) tick();
        idle();
        #1;
        checks++;
        if (conflict_cnt !== 32'd10 || forced_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_counters: conflict=%0d forced=%0d want 10 2", conflict_cnt, forced_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[4] = 32'h1111_0004;
        mem[8] = 32'h2222_0008;
        mem_rdata = '0;
        reset = 1'b0;
        idle();
        #2;
        test_reset();
        test_core_reads();
        test_ldr_write_core_read();
        test_starvation();
        test_reset_mid_read();
        test_ldr_then_core();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
